rlbp_pixel_sequencer: RTL

- Digital timing sequencer that drives the analog pixel/readout chain: photodiode select lines, reset, sample-hold, compare and switch controls.
- Captures the comparator result for each of 12 photodiodes and assembles a 12-bit local-binary-pattern code.
- Sits inside the digital controller, directly upstream of the analog SystemLevel block, whose CMP output it consumes.
- Delivers the code to the register/Wishbone side through a valid/ready handshake.

---
 rtl/rlbp_pixel_sequencer_if.sv | 13 +
 rtl/rlbp_pixel_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rlbp_pixel_sequencer_if.sv
// Code delivery channel from the pixel sequencer to the register side.
// valid/ready: code is held stable while code_valid=1; a transfer happens on
// every clock edge where code_valid and code_ready are both high.
interface rlbp_pixel_sequencer_if #(
  parameter int NPIX = 12
);
  logic [NPIX-1:0] code;
  logic            code_valid;
  logic            code_ready;

  modport master (output code, output code_valid, input code_ready);
  modport slave  (input code, input code_valid, output code_ready);
endinterface

// File: rtl/rlbp_pixel_sequencer.sv
// Frame sequencer for the analog pixel chain: reset, integrate, sample the
// reference, then compare each photodiode in turn to build an LBP code.
module rlbp_pixel_sequencer #(
  parameter int NPIX  = 12,
  parameter int T_RST = 8,
  parameter int T_SH  = 8,
  parameter int T_CMP = 4,
  parameter int TW    = 16
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  start,
  input  logic                  abort,
  input  logic [TW-1:0]         t_int,
  output logic [NPIX-1:0]       pd_a,
  output logic [NPIX-1:0]       pd_b,
  output logic                  sh_rst,
  output logic                  sw1,
  output logic                  sw2,
  output logic                  sh,
  output logic                  sh_cmp,
  input  logic                  cmp_in,
  output logic                  busy,
  rlbp_pixel_sequencer_if.master code_if,
  output logic                  overrun,
  input  logic                  overrun_clr,
  output logic [2:0]            state_dbg
);

  localparam int IW = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [IW-1:0] LAST_PIX = IW'(NPIX - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_INTEG, S_SH, S_SEL, S_CMP, S_DONE
  } state_t;

  state_t          state, state_n;
  logic [TW-1:0]   cnt, cnt_n, t_lat;
  logic [IW-1:0]   idx, idx_n;
  logic [NPIX-1:0] shadow;
  logic [1:0]      cmp_sync;
  logic            start_frame, capture, publish, ovr_set, accept;

  logic [NPIX-1:0] pd_a_n, pd_b_n, onehot_n;
  logic            sh_rst_n, sw1_n, sw2_n, sh_n, sh_cmp_n, busy_n;

  assign state_dbg = state;

  // cnt holds the remaining cycles of the current state minus one.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt - TW'(1);
    idx_n       = idx;
    start_frame = 1'b0;
    capture     = 1'b0;
    publish     = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (start && !abort) begin
          state_n     = S_RST;
          cnt_n       = TW'(T_RST - 1);
          start_frame = 1'b1;
        end
      end
      S_RST: if (cnt == '0) begin
        state_n = S_INTEG;
        cnt_n   = (t_lat == '0) ? '0 : t_lat - TW'(1);
      end
      S_INTEG: if (cnt == '0) begin
        state_n = S_SH;
        cnt_n   = TW'(T_SH - 1);
      end
      S_SH: if (cnt == '0) begin
        state_n = S_SEL;
        idx_n   = '0;
        cnt_n   = '0;
      end
      S_SEL: begin
        state_n = S_CMP;
        cnt_n   = TW'(T_CMP - 1);
      end
      S_CMP: if (cnt == '0) begin
        capture = 1'b1;
        cnt_n   = '0;
        if (idx == LAST_PIX) begin
          state_n = S_DONE;
        end else begin
          idx_n   = idx + IW'(1);
          state_n = S_SEL;
        end
      end
      S_DONE: begin
        publish = 1'b1;
        state_n = S_IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
    if (abort && state != S_IDLE) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      idx_n   = '0;
      capture = 1'b0;
      publish = 1'b0;
    end
  end

  // Controls are decoded from the next state so they register in step with it.
  always_comb begin
    pd_a_n   = '0;
    pd_b_n   = '0;
    sh_rst_n = 1'b0;
    sw1_n    = 1'b0;
    sw2_n    = 1'b0;
    sh_n     = 1'b0;
    sh_cmp_n = 1'b0;
    busy_n   = (state_n != S_IDLE);
    onehot_n = {{(NPIX-1){1'b0}}, 1'b1} << idx_n;
    case (state_n)
      S_RST: begin
        sh_rst_n = 1'b1;
        pd_a_n   = '1;
        pd_b_n   = '1;
      end
      S_INTEG: sw1_n = 1'b1;
      S_SH: begin
        sh_n   = 1'b1;
        sw2_n  = 1'b1;
        pd_a_n = '1;
      end
      S_SEL: pd_b_n = onehot_n;
      S_CMP: begin
        pd_b_n   = onehot_n;
        sh_cmp_n = 1'b1;
      end
      default: ;
    endcase
  end

  assign ovr_set = publish && code_if.code_valid && !code_if.code_ready;
  assign accept  = publish && !ovr_set;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state              <= S_IDLE;
      cnt                <= '0;
      idx                <= '0;
      t_lat              <= '0;
      shadow             <= '0;
      cmp_sync           <= '0;
      pd_a               <= '0;
      pd_b               <= '0;
      sh_rst             <= 1'b0;
      sw1                <= 1'b0;
      sw2                <= 1'b0;
      sh                 <= 1'b0;
      sh_cmp             <= 1'b0;
      busy               <= 1'b0;
      code_if.code       <= '0;
      code_if.code_valid <= 1'b0;
      overrun            <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      cmp_sync <= {cmp_sync[0], cmp_in};
      if (start_frame) begin
        t_lat  <= t_int;
        shadow <= '0;
      end
      if (capture) shadow[idx] <= cmp_sync[1];
      pd_a   <= pd_a_n;
      pd_b   <= pd_b_n;
      sh_rst <= sh_rst_n;
      sw1    <= sw1_n;
      sw2    <= sw2_n;
      sh     <= sh_n;
      sh_cmp <= sh_cmp_n;
      busy   <= busy_n;
      if (accept) begin
        code_if.code       <= shadow;
        code_if.code_valid <= 1'b1;
      end else if (code_if.code_valid && code_if.code_ready) begin
        code_if.code_valid <= 1'b0;
      end
      // A new overrun in the same cycle as a clear takes priority.
      if (ovr_set) overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

endmodule
